// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer
// Byte-level command sequencer between the I2C master register block and the
// bit controller. Expands START/STOP/READ/WRITE(+ACK) byte commands into a
// back-to-back stream of single-bit commands and reports completion.
//
// Ports
//   wb_clk_i, wb_rst_ni           clock, synchronous active-low reset
//   ena_i                         core enable
//   start_i/stop_i/read_i/write_i byte command bits (held until cmd_ack_o)
//   ack_in_i                      ACK bit to send after a read (1 = NACK)
//   din_i                         byte to transmit
//   cmd_ack_o                     one-cycle pulse, byte command complete
//   ack_out_o                     ACK sampled from slave in the last ACK slot
//   dout_o                        received byte
//   al_o                          one-cycle pulse, arbitration lost
//   bit_cmd_o, bit_din_o          bit command to the bit controller
//   bit_ack_i, bit_dout_i         bit command done / sampled SDA bit
//   bit_al_i                      arbitration lost from the bit controller
module i2c_byte_sequencer #(
  parameter int DW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          ena_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          read_i,
  input  logic          write_i,
  input  logic          ack_in_i,
  input  logic [DW-1:0] din_i,
  output logic          cmd_ack_o,
  output logic          ack_out_o,
  output logic [DW-1:0] dout_o,
  output logic          al_o,
  output logic [3:0]    bit_cmd_o,
  output logic          bit_din_o,
  input  logic          bit_ack_i,
  input  logic          bit_dout_i,
  input  logic          bit_al_i
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_START = 4'd1;
  localparam logic [3:0] CMD_STOP  = 4'd2;
  localparam logic [3:0] CMD_WRITE = 4'd4;
  localparam logic [3:0] CMD_READ  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_cmd_q, bit_cmd_d;
  logic            bit_din_q, bit_din_d;
  logic            cmd_ack_q, cmd_ack_d;
  logic            ack_out_q, ack_out_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            al_q, al_d;
  // Remembers whether the current byte was a read, so ACK completion knows
  // whether to publish the shift register to dout_o.
  logic            rd_q, rd_d;
  logic            go_s;
  logic            cnt_zero_s;

  // Command bits stay high until cmd_ack_o; masking with cmd_ack_q stops a
  // relaunch in the completion cycle.
  assign go_s       = ena_i & (start_i | stop_i | read_i | write_i) & ~cmd_ack_q;
  assign cnt_zero_s = (cnt_q == {CW{1'b0}});

  // State and datapath register with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      shreg_q   <= {DW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      bit_cmd_q <= CMD_NOP;
      bit_din_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      dout_q    <= {DW{1'b0}};
      al_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      bit_cmd_q <= bit_cmd_d;
      bit_din_q <= bit_din_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      dout_q    <= dout_d;
      al_q      <= al_d;
      rd_q      <= rd_d;
    end
  end

  // Next-state logic; arbitration loss and disable abort to IDLE first.
  always_comb begin
    state_d = state_q;
    if (bit_al_i) begin
      state_d = ST_IDLE;
    end else if (!ena_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_s) begin
            if (start_i)      state_d = ST_START;
            else if (read_i)  state_d = ST_READ;
            else if (write_i) state_d = ST_WRITE;
            else              state_d = ST_STOP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (bit_ack_i) begin
            if (read_i)       state_d = ST_READ;
            else if (write_i) state_d = ST_WRITE;
            else              state_d = ST_IDLE;
          end else begin
            state_d = ST_START;
          end
        end
        ST_WRITE, ST_READ: begin
          if (bit_ack_i && cnt_zero_s) state_d = ST_ACK;
          else                         state_d = state_q;
        end
        ST_ACK: begin
          if (bit_ack_i) state_d = stop_i ? ST_STOP : ST_IDLE;
          else           state_d = ST_ACK;
        end
        ST_STOP: begin
          if (bit_ack_i) state_d = ST_IDLE;
          else           state_d = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath logic; the next bit command is issued on the same
  // edge that consumes bit_ack_i so bit commands run back-to-back.
  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    bit_cmd_d = bit_cmd_q;
    bit_din_d = bit_din_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    dout_d    = dout_q;
    al_d      = 1'b0;
    rd_d      = rd_q;
    if (bit_al_i) begin
      // Counter and shift register are left as-is; the next launch reloads them.
      al_d      = 1'b1;
      bit_cmd_d = CMD_NOP;
    end else if (!ena_i) begin
      bit_cmd_d = CMD_NOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_s) begin
            shreg_d   = din_i;
            cnt_d     = CW'(DW - 1);
            bit_din_d = din_i[DW-1];
            rd_d      = read_i & ~start_i;
            if (start_i)      bit_cmd_d = CMD_START;
            else if (read_i)  bit_cmd_d = CMD_READ;
            else if (write_i) bit_cmd_d = CMD_WRITE;
            else              bit_cmd_d = CMD_STOP;
          end else begin
            bit_cmd_d = CMD_NOP;
          end
        end
        ST_START: begin
          if (bit_ack_i) begin
            if (read_i) begin
              bit_cmd_d = CMD_READ;
              rd_d      = 1'b1;
            end else if (write_i) begin
              bit_cmd_d = CMD_WRITE;
              rd_d      = 1'b0;
            end else begin
              bit_cmd_d = CMD_NOP;
              cmd_ack_d = 1'b1;
            end
          end else begin
            bit_cmd_d = CMD_START;
          end
        end
        ST_WRITE: begin
          if (bit_ack_i) begin
            shreg_d   = {shreg_q[DW-2:0], 1'b0};
            bit_din_d = shreg_q[DW-2];
            if (cnt_zero_s) begin
              bit_cmd_d = CMD_READ;        // sample the slave ACK
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end else begin
            bit_cmd_d = CMD_WRITE;
          end
        end
        ST_READ: begin
          if (bit_ack_i) begin
            shreg_d = {shreg_q[DW-2:0], bit_dout_i};
            if (cnt_zero_s) begin
              bit_cmd_d = CMD_WRITE;       // drive our ACK/NACK
              bit_din_d = ack_in_i;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end else begin
            bit_cmd_d = CMD_READ;
          end
        end
        ST_ACK: begin
          if (bit_ack_i) begin
            ack_out_d = bit_dout_i;
            if (rd_q) dout_d = shreg_q;
            else      dout_d = dout_q;
            if (stop_i) begin
              bit_cmd_d = CMD_STOP;
            end else begin
              bit_cmd_d = CMD_NOP;
              cmd_ack_d = 1'b1;
            end
          end else begin
            bit_cmd_d = bit_cmd_q;
          end
        end
        ST_STOP: begin
          if (bit_ack_i) begin
            bit_cmd_d = CMD_NOP;
            cmd_ack_d = 1'b1;
          end else begin
            bit_cmd_d = CMD_STOP;
          end
        end
        default: bit_cmd_d = CMD_NOP;
      endcase
    end
  end

  assign cmd_ack_o = cmd_ack_q;
  assign ack_out_o = ack_out_q;
  assign dout_o    = dout_q;
  assign al_o      = al_q;
  assign bit_cmd_o = bit_cmd_q;
  assign bit_din_o = bit_din_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Table-driven bench for i2c_byte_sequencer with a small bit-controller
// responder plus directed sequences for reset, arbitration and enable.
module tb_i2c_byte_sequencer;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_ni = 1'b0;
  logic       ena_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, read_i = 1'b0;
  logic       write_i = 1'b0, ack_in_i = 1'b0;
  logic [7:0] din_i = 8'h00;
  logic       cmd_ack_o, ack_out_o, al_o, bit_din_o;
  logic [7:0] dout_o;
  logic [3:0] bit_cmd_o;
  logic       bit_ack_i = 1'b0, bit_dout_i = 1'b0, bit_al_i = 1'b0;

  int errors = 0;
  int checks = 0;

  i2c_byte_sequencer #(.DW(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .ena_i(ena_i),
    .start_i(start_i), .stop_i(stop_i), .read_i(read_i), .write_i(write_i),
    .ack_in_i(ack_in_i), .din_i(din_i), .cmd_ack_o(cmd_ack_o),
    .ack_out_o(ack_out_o), .dout_o(dout_o), .al_o(al_o),
    .bit_cmd_o(bit_cmd_o), .bit_din_o(bit_din_o), .bit_ack_i(bit_ack_i),
    .bit_dout_i(bit_dout_i), .bit_al_i(bit_al_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // One byte-command vector: command bits, data, slave behaviour, and the
  // expected bit-command log (oldest entry in the most significant nibble).
  typedef struct {
    logic        start, stop, read, write, ack_in;
    logic [7:0]  din;
    logic [7:0]  rx;       // bits the slave returns on data reads, MSB first
    logic        sack;     // slave ACK bit for a write
    int          n;        // number of bit commands expected
    logic [47:0] cmds;
    logic [11:0] dins;     // bit_din_o per logged WRITE bit command, 0 otherwise
    logic [7:0]  dout;
    logic        ack_out;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one byte command to completion against a responder that acks each
  // bit command three cycles after it appears.
  task automatic run_vec(input int idx, input vec_t v);
    logic [47:0] lc = 48'h0;
    logic [11:0] ld = 12'h0;
    int   n = 0, rd = 0, w = 0, alc = 0;
    bit   fresh = 1'b1, done = 1'b0, prev_ack;
    @(negedge wb_clk_i);
    start_i = v.start; stop_i = v.stop; read_i = v.read; write_i = v.write;
    ack_in_i = v.ack_in; din_i = v.din;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge wb_clk_i);
      prev_ack  = bit_ack_i;
      bit_ack_i = 1'b0;
      if (al_o) alc++;
      if (cmd_ack_o) begin
        done = 1'b1;
        chk($sformatf("v%0d_ack_latency", idx), 64'(prev_ack), 64'd1);
        chk($sformatf("v%0d_nop_at_done", idx), 64'(bit_cmd_o), 64'd0);
      end else if (bit_cmd_o != 4'd0) begin
        if (fresh) begin
          lc = {lc[43:0], bit_cmd_o};
          ld = {ld[10:0], (bit_cmd_o == 4'd4) ? bit_din_o : 1'b0};
          n++;
          fresh = 1'b0;
          w = 0;
        end else begin
          w++;
          if (w == 3) begin
            bit_ack_i = 1'b1;
            fresh = 1'b1;
            if (bit_cmd_o == 4'd8) begin
              if (v.read && rd < 8) begin
                bit_dout_i = v.rx[7-rd];
                rd++;
              end else begin
                bit_dout_i = v.sack;
              end
            end else begin
              bit_dout_i = bit_din_o;   // bus echoes what we drive
            end
          end
        end
      end
    end
    chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
    // Command bits are still held through the completion cycle.
    @(negedge wb_clk_i);
    chk($sformatf("v%0d_no_relaunch", idx), 64'({bit_cmd_o, cmd_ack_o}), 64'd0);
    start_i = 1'b0; stop_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    chk($sformatf("v%0d_count", idx), 64'(n), 64'(v.n));
    chk($sformatf("v%0d_cmds", idx), 64'(lc), 64'(v.cmds));
    chk($sformatf("v%0d_dins", idx), 64'(ld), 64'(v.dins));
    chk($sformatf("v%0d_dout", idx), 64'(dout_o), 64'(v.dout));
    chk($sformatf("v%0d_ack_out", idx), 64'(ack_out_o), 64'(v.ack_out));
    chk($sformatf("v%0d_al_quiet", idx), 64'(alc), 64'd0);
  endtask

  // Issues n bit acks (reads return 0); optionally raises bit_al_i with the last.
  task automatic serve(input int n, input bit al_last);
    int w = 0, k = 0;
    for (int cyc = 0; cyc < 200 && k < n; cyc++) begin
      @(negedge wb_clk_i);
      bit_ack_i = 1'b0;
      if (bit_cmd_o != 4'd0) begin
        w++;
        if (w == 3) begin
          w = 0;
          k++;
          bit_ack_i  = 1'b1;
          bit_dout_i = 1'b0;
          if (al_last && k == n) bit_al_i = 1'b1;
        end
      end
    end
    chk("serve_budget", 64'(k), 64'(n));
  endtask

  initial begin
    logic seen;
    //           start stop read write ackin din    rx     sack n   cmds              dins             dout   ack_out
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 10, 48'h001444444448, 12'b000101001010, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h69, 1'b0, 10, 48'h008888888842, 12'b000000000010, 8'h69, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1,  48'h000000000002, 12'b000000000000, 8'h69, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 9,  48'h000444444448, 12'b000001111000, 8'h69, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h96, 1'b0, 10, 48'h001888888884, 12'b000000000000, 8'h96, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 11, 48'h014444444482, 12'b001111111100, 8'h96, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 9,  48'h000444444448, 12'b000101001010, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("reset_outputs", 64'({bit_cmd_o, bit_din_o, cmd_ack_o, al_o, ack_out_o, dout_o}), 64'd0);
    wb_rst_ni = 1'b1;
    ena_i = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Arbitration lost together with the 5th write-bit ack
    @(negedge wb_clk_i);
    write_i = 1'b1; din_i = 8'hA5;
    serve(5, 1'b1);
    @(negedge wb_clk_i);
    bit_ack_i = 1'b0; bit_al_i = 1'b0; write_i = 1'b0;
    chk("al_pulse", 64'(al_o), 64'd1);
    chk("al_idle", 64'({bit_cmd_o, cmd_ack_o}), 64'd0);
    @(negedge wb_clk_i);
    chk("al_one_cycle", 64'({al_o, cmd_ack_o, bit_cmd_o}), 64'd0);

    // Disabled core ignores commands
    ena_i = 1'b0; write_i = 1'b1; din_i = 8'hFF;
    seen = 1'b0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (bit_cmd_o != 4'd0) seen = 1'b1;
    end
    chk("disabled_no_cmd", 64'(seen), 64'd0);
    write_i = 1'b0; ena_i = 1'b1; read_i = 1'b1;
    serve(3, 1'b0);
    @(negedge wb_clk_i);
    bit_ack_i = 1'b0; ena_i = 1'b0;
    @(negedge wb_clk_i);
    read_i = 1'b0;
    chk("ena_drop_idle", 64'({bit_cmd_o, cmd_ack_o, al_o}), 64'd0);
    chk("ena_drop_dout", 64'(dout_o), 64'h96);
    ena_i = 1'b1;

    // Reset in the middle of a write after 3 bit acks (0x5A -> next bit 1)
    @(negedge wb_clk_i);
    write_i = 1'b1; din_i = 8'h5A;
    serve(3, 1'b0);
    @(negedge wb_clk_i);
    bit_ack_i = 1'b0; wb_rst_ni = 1'b0; write_i = 1'b0;
    @(negedge wb_clk_i);
    chk("midop_reset", 64'({bit_cmd_o, bit_din_o, cmd_ack_o, al_o, ack_out_o, dout_o}), 64'd0);
    wb_rst_ni = 1'b1;
    run_vec(6, tbl[6]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_byte_sequencer.md
Name: i2c_byte_sequencer

Overview:
- Byte-level command sequencer sitting directly downstream of the I2C master's WISHBONE register block, between it and the I2C bit controller.
- Accepts START/STOP/READ/WRITE/ACK commands plus a transmit byte from the command/transmit registers.
- Expands each command into single-bit controller commands.
- Returns the received byte, the received ACK, a command-done pulse and arbitration-lost to the register block.

Parameters:
- DW, 8, data byte width (shift register and bit count); only 8 is required to be supported.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_ni  in  1  synchronous active-low reset.
- ena_i  in  1  core enable (control register EN bit).
- start_i  in  1  generate START before byte transfer.
- stop_i  in  1  generate STOP after byte transfer, or standalone STOP.
- read_i  in  1  read one byte from slave.
- write_i  in  1  write one byte to slave.
- ack_in_i  in  1  ACK bit to send after a read (0 = ACK, 1 = NACK).
- din_i  in  DW  byte to transmit (transmit register).
- cmd_ack_o  out  1  one-cycle pulse: whole command complete (register block uses it as done).
- ack_out_o  out  1  ACK bit sampled from slave in the last ACK slot.
- dout_o  out  DW  received byte.
- al_o  out  1  one-cycle pulse: arbitration lost.
- bit_cmd_o  out  4  bit command: 0 = NOP, 1 = START, 2 = STOP, 4 = WRITE, 8 = READ.
- bit_din_o  out  1  bit to drive for a WRITE bit command.
- bit_ack_i  in  1  one-cycle pulse: current bit command finished.
- bit_dout_i  in  1  bit sampled on SDA, valid with bit_ack_i.
- bit_al_i  in  1  arbitration lost, level or pulse.

Behaviour:
- Reset (wb_rst_ni = 0 at a clock edge):
  - state IDLE; all outputs 0 (bit_cmd_o NOP, dout_o 0x00).
  - shift register 0, bit counter 0.
  - Applies mid-operation too; no partial state survives.
- All outputs are registered; bit_cmd_o is held stable until bit_ack_i.
- go = ena_i & (start_i | stop_i | read_i | write_i) & !cmd_ack_o. Command bits stay set until cmd_ack_o, so !cmd_ack_o blocks re-launch in the done cycle.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE on go, priority start > read > write > stop:
  - start: → START, bit_cmd START.
  - read: → READ, bit_cmd READ.
  - write: → WRITE, bit_cmd WRITE.
  - stop: → STOP, bit_cmd STOP.
  - Every launch loads shreg ← din_i, bit counter ← DW-1, and sets bit_din_o ← din_i[DW-1].
- START, on bit_ack_i:
  - → READ if read_i, else → WRITE if write_i (bit_cmd to match).
  - Otherwise → IDLE with a cmd_ack_o pulse (bare START).
- WRITE, on each bit_ack_i: shift left, bit_din_o ← next MSB, counter decrements.
  - When counter == 0 at bit_ack_i: → ACK, bit_cmd READ (sample slave ACK).
- READ, on each bit_ack_i: shreg ← {shreg[DW-2:0], bit_dout_i}, counter decrements.
  - When counter == 0: → ACK, bit_cmd WRITE, bit_din_o ← ack_in_i.
- ACK, on bit_ack_i:
  - ack_out_o ← bit_dout_i.
  - dout_o ← shreg (after a READ only).
  - If stop_i: → STOP, bit_cmd STOP.
  - Else: → IDLE, bit_cmd NOP, cmd_ack_o pulse.
- STOP, on bit_ack_i: → IDLE, bit_cmd NOP, cmd_ack_o pulse.
- Bit commands are back-to-back: the next command is presented on the edge that samples bit_ack_i, with no NOP gap.
- Arbitration lost (bit_al_i = 1 in any state):
  - Next edge: → IDLE, bit_cmd NOP, al_o pulse for 1 cycle.
  - No cmd_ack_o; counter and shreg are not reloaded until the next go.
  - Takes priority over a simultaneous bit_ack_i.
- ena_i deasserted outside IDLE: → IDLE, bit_cmd NOP, no cmd_ack_o, no al_o.
- ack_out_o and dout_o hold their values until the next ACK completion or reset.
- bit_ack_i in IDLE is ignored.
- Latency:
  - write byte = 9 bit_acks; the cmd_ack_o edge is the one sampling the 9th.
  - start+write+stop = 11 bit_acks.

Test Plan:
- Reset mid-WRITE after 3 bit_acks → next cycle bit_cmd_o = 0, all outputs 0, state IDLE; a fresh write of 0xA5 then shifts 1,0,1,0,0,1,0,1 from the first bit.
- start_i = write_i = 1, din_i = 0xA5, bit_ack_i pulses 3 cycles after each command → bit_cmd_o sequence: 1, then 4 ×8 with bit_din_o = 1,0,1,0,0,1,0,1, then 8; bit_dout_i = 0 on the 10th ack → ack_out_o = 0, single cmd_ack_o pulse, no STOP issued.
- read_i = stop_i = 1, ack_in_i = 1, bit_dout_i = 0,1,1,0,1,0,0,1 → dout_o = 0x69, ACK-slot bit_din_o = 1 with bit_cmd 4, then bit_cmd 2, cmd_ack_o one cycle after the STOP ack.
- Standalone stop_i → bit_cmd_o = 2 until ack → cmd_ack_o one pulse; command bits held high during the cmd_ack_o cycle → no relaunch.
- bit_al_i = 1 together with bit_ack_i during the 5th write bit → al_o pulse, IDLE, bit_cmd_o = 0, no cmd_ack_o.
- ena_i = 0 with write_i = 1 → bit_cmd_o stays 0; dropping ena_i mid-READ → IDLE, dout_o unchanged.
